mpsram_clr: RTL

- Parametrised multi-read-port, single-write-port synchronous SRAM with per-byte write enables.
- Adds a selectable read-during-write mode, a selectable read latency of 1 or 2 cycles, and a hardware clear-on-reset sequencer.
- The sequencer replaces the single-cycle bulk simulation reset and is synthesisable.
- Used for tag, valid and metadata arrays in the caches and predictors, where several pipeline stages read one array per cycle.

---
 rtl/mpsram_clr.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mpsram_clr.sv
// Multi-read-port, single-write-port SRAM with byte enables, a selectable read latency
// and read-during-write mode, plus a sequencer that zeroes every word after reset.
module mpsram_clr #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DATA_DEPTH     = 1024,
    parameter int unsigned BYTE_SIZE      = 8,
    parameter int unsigned RD_PORTS       = 2,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned WRITE_MODE     = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    output logic                                    init_busy_o,
    input  logic                                    wr_en_i,
    input  logic [$clog2(DATA_DEPTH)-1:0]           wr_addr_i,
    input  logic [DATA_WIDTH/BYTE_SIZE-1:0]         wr_be_i,
    input  logic [DATA_WIDTH-1:0]                   wr_data_i,
    input  logic [RD_PORTS-1:0]                     rd_en_i,
    input  logic [RD_PORTS*$clog2(DATA_DEPTH)-1:0]  rd_addr_i,
    output logic [RD_PORTS*DATA_WIDTH-1:0]          rd_data_o,
    output logic [RD_PORTS-1:0]                     rd_valid_o
);

    localparam int unsigned AW = $clog2(DATA_DEPTH);
    localparam int unsigned NB = DATA_WIDTH / BYTE_SIZE;

    if (DATA_WIDTH % BYTE_SIZE != 0) begin : g_err_byte
        $error("DATA_WIDTH must be a multiple of BYTE_SIZE");
    end
    if (RD_PORTS < 1 || RD_PORTS > 4) begin : g_err_ports
        $error("RD_PORTS must be 1..4");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_err_lat
        $error("READ_LATENCY must be 1 or 2");
    end
    if (DATA_DEPTH < 2) begin : g_err_depth
        $error("DATA_DEPTH must be at least 2");
    end

    typedef enum logic {StClear, StReady} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
    logic            busy_q, busy_d;
    logic            ready;
    logic            wr_ok;

    logic [DATA_WIDTH-1:0]                  mem [DATA_DEPTH];
    logic [RD_PORTS-1:0][AW-1:0]            rd_addr;
    logic [RD_PORTS-1:0][DATA_WIDTH-1:0]    rd_word;
    logic [RD_PORTS-1:0][DATA_WIDTH-1:0]    s1_data_q;
    logic [RD_PORTS-1:0]                    s1_valid_q;

    assign ready       = (state_q == StReady);
    assign wr_ok       = wr_en_i && ready && (32'(wr_addr_i) < DATA_DEPTH);
    assign rd_addr     = rd_addr_i;
    assign init_busy_o = busy_q;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == StClear) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == AW'(DATA_DEPTH - 1)) begin
                state_d   = StReady;
                clr_ptr_d = '0;
            end
        end
        busy_d = (state_d == StClear);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? StClear : StReady;
            clr_ptr_q <= '0;
            busy_q    <= (CLEAR_ON_RESET != 0);
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
        end
    end

    // Storage has no reset of its own; the clear sequencer owns the write port while busy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StClear) begin
                mem[clr_ptr_q] <= '0;
            end else if (wr_ok) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_be_i[b]) begin
                        mem[wr_addr_i][b*BYTE_SIZE +: BYTE_SIZE] <= wr_data_i[b*BYTE_SIZE +: BYTE_SIZE];
                    end
                end
            end
        end
    end

    // Write-first bypass merges enabled bytes; read-first simply returns the stored word.
    always_comb begin
        rd_word = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            if (32'(rd_addr[p]) < DATA_DEPTH) begin
                rd_word[p] = mem[rd_addr[p]];
                if (WRITE_MODE == 0 && wr_ok && rd_addr[p] == wr_addr_i) begin
                    for (int b = 0; b < NB; b++) begin
                        if (wr_be_i[b]) begin
                            rd_word[p][b*BYTE_SIZE +: BYTE_SIZE] = wr_data_i[b*BYTE_SIZE +: BYTE_SIZE];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= '0;
            s1_data_q  <= '0;
        end else begin
            for (int p = 0; p < RD_PORTS; p++) begin
                s1_valid_q[p] <= ready && rd_en_i[p];
                if (ready && rd_en_i[p]) begin
                    s1_data_q[p] <= rd_word[p];
                end
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [RD_PORTS-1:0][DATA_WIDTH-1:0] s2_data_q;
        logic [RD_PORTS-1:0]                 s2_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_valid_q <= '0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                for (int p = 0; p < RD_PORTS; p++) begin
                    if (s1_valid_q[p]) begin
                        s2_data_q[p] <= s1_data_q[p];
                    end
                end
            end
        end

        assign rd_data_o  = s2_data_q;
        assign rd_valid_o = s2_valid_q;
    end else begin : g_lat1
        assign rd_data_o  = s1_data_q;
        assign rd_valid_o = s1_valid_q;
    end

endmodule
